knn_list_reader: RTL and testbench

- Read side of the KNN sorted neighbour list; the insertion elements are the write side.
- On `start`, snapshots all K list registers and streams the valid entries in ascending-distance order over a valid/ready interface.
- Accumulates a per-class vote while streaming, then resolves the plurality label for the classifier result register.

---
 rtl/knn_list_reader_pkg.sv | 24 ++
 rtl/knn_list_reader_if.sv | 30 +++
 rtl/knn_list_reader_vote_counter.sv | 63 ++++++
 rtl/knn_list_reader.sv | 177 +++++++++++++++++
 tb/tb_knn_list_reader.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/knn_list_reader_pkg.sv
// knn_list_reader_pkg
// Shared definitions for the KNN list reader: the reader FSM state encoding
// and the width helpers used to size list indices, entry counts and class
// indices.
package knn_list_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_VOTE   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Width of an index into a list of k elements, never narrower than 1 bit.
    function automatic int idx_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

    // Width able to hold a count of 0..k inclusive.
    function automatic int cnt_width(input int k);
        return (k > 1) ? $clog2(k + 1) : 1;
    endfunction

endpackage

// File: rtl/knn_list_reader_if.sv
// knn_list_reader_if
// Valid/ready stream carrying one neighbour-list entry per beat.
//   out_valid / out_ready : handshake
//   out_dist              : entry distance
//   out_label             : entry label
//   out_idx               : entry position in the list
//   out_last              : final valid entry of the list
// master = stream source (the reader), slave = stream sink.
interface knn_list_reader_if #(
    parameter int DATA_W = 32,
    parameter int LABEL  = 8,
    parameter int IDX_W  = 3
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_dist;
    logic [LABEL-1:0]  out_label;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;

    modport master (
        output out_valid, out_dist, out_label, out_idx, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_dist, out_label, out_idx, out_last,
        output out_ready
    );
endinterface

// File: rtl/knn_list_reader_vote_counter.sv
// knn_list_reader_vote_counter
// Per-class vote counters plus a sequential argmax scan.
//   clk, rst    : clock, synchronous active-low reset
//   clear       : zero all counters, the scan index and the best candidate
//   inc         : count one vote for inc_label (ignored if out of class range)
//   scan_en     : advance the argmax scan by one class this cycle
//   scan_done   : the class being examined this cycle is the last one
//   best_label  : current plurality label (lowest label wins ties)
//   best_count  : vote count of best_label
module knn_list_reader_vote_counter
    import knn_list_reader_pkg::*;
#(
    parameter int K           = 8,
    parameter int NUM_CLASSES = 16,
    parameter int LABEL       = 8,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    input  logic [LABEL-1:0] inc_label,
    input  logic             scan_en,
    output logic             scan_done,
    output logic [LABEL-1:0] best_label,
    output logic [CNT_W-1:0] best_count
);

    localparam int CLS_W = idx_width(NUM_CLASSES);

    logic [CNT_W-1:0] counts [NUM_CLASSES];
    logic [CLS_W-1:0] scan_idx;
    logic [CLS_W-1:0] inc_cls;
    logic             inc_hit;

    assign inc_cls   = inc_label[CLS_W-1:0];
    assign inc_hit   = inc && (int'(inc_label) < NUM_CLASSES);
    assign scan_done = scan_en && (scan_idx == CLS_W'(NUM_CLASSES - 1));

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                counts[i] <= '0;
            end
            scan_idx   <= '0;
            best_label <= '0;
            best_count <= '0;
        end else begin
            if (inc_hit && (counts[inc_cls] != CNT_W'(K))) begin
                counts[inc_cls] <= counts[inc_cls] + CNT_W'(1);
            end
            if (scan_en) begin
                // Strict compare keeps the earliest (lowest) label on a tie.
                if (counts[scan_idx] > best_count) begin
                    best_count <= counts[scan_idx];
                    best_label <= LABEL'(scan_idx);
                end
                scan_idx <= scan_idx + CLS_W'(1);
            end
        end
    end

endmodule

// File: rtl/knn_list_reader.sv
// knn_list_reader
// Read side of the KNN sorted neighbour list. On start the whole list is
// snapshotted, the non-empty prefix is streamed nearest-first, and a
// plurality vote over the streamed labels is resolved afterwards.
//   clk, rst    : clock, synchronous active-low reset
//   start       : one-cycle request to snapshot and read the list
//   list_in     : K entries of {dist, label}, entry 0 in the low bits
//   busy        : request in progress (until the vote result appears)
//   strm        : entry stream (valid/ready, dist, label, idx, last)
//   vote_valid  : vote result valid, held until the next accepted start
//   vote_label  : plurality label
//   vote_count  : occurrences of vote_label
//   n_valid     : number of non-empty entries in the snapshot
//
// state   | meaning
// IDLE    | waiting for start; results of the previous request held
// STREAM  | presenting snapshot entry ptr on the stream
// VOTE    | scanning the class counters, one class per cycle
// DONE    | one cycle with the final vote presented, then IDLE
module knn_list_reader
    import knn_list_reader_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int LABEL       = 8,
    parameter int K           = 8,
    parameter int NUM_CLASSES = 16,
    localparam int IDX_W      = idx_width(K),
    localparam int CNT_W      = cnt_width(K)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [K*(DATA_W+LABEL)-1:0] list_in,
    output logic                      busy,
    knn_list_reader_if.master         strm,
    output logic                      vote_valid,
    output logic [LABEL-1:0]          vote_label,
    output logic [CNT_W-1:0]          vote_count,
    output logic [CNT_W-1:0]          n_valid
);

    localparam int                EW         = DATA_W + LABEL;
    localparam logic [DATA_W-1:0] DIST_EMPTY = '1;

    state_t           state;
    state_t           state_nx;
    logic [DATA_W-1:0] snap_dist  [K];
    logic [LABEL-1:0]  snap_label [K];
    logic [IDX_W-1:0]  ptr;
    logic [CNT_W-1:0]  n_valid_q;
    logic [CNT_W-1:0]  n_valid_in;
    logic              vote_valid_q;
    logic              accept;
    logic              beat_fire;
    logic              beat_last;
    logic              scan_done;
    logic [LABEL-1:0]  best_label;
    logic [CNT_W-1:0]  best_count;

    assign accept    = (state == ST_IDLE) && start;
    assign beat_fire = (state == ST_STREAM) && strm.out_ready;
    assign beat_last = (state == ST_STREAM) &&
                       ((CNT_W'(ptr) + CNT_W'(1)) == n_valid_q);

    // The list is sorted with empties at the tail, so the first empty entry
    // marks the end of the valid region. Scanning downward lets the lowest
    // empty index win without a found flag.
    always_comb begin
        n_valid_in = CNT_W'(K);
        for (int i = K - 1; i >= 0; i--) begin
            if (list_in[i*EW+LABEL +: DATA_W] == DIST_EMPTY) begin
                n_valid_in = CNT_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = (n_valid_in != '0) ? ST_STREAM : ST_VOTE;
                end
            end
            ST_STREAM: begin
                if (beat_fire && beat_last) begin
                    state_nx = ST_VOTE;
                end
            end
            ST_VOTE: begin
                if (scan_done) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy           = (state == ST_STREAM) || (state == ST_VOTE);
        strm.out_valid = (state == ST_STREAM);
        strm.out_dist  = '0;
        strm.out_label = '0;
        strm.out_idx   = '0;
        strm.out_last  = beat_last;
        if (state == ST_STREAM) begin
            strm.out_dist  = snap_dist[ptr];
            strm.out_label = snap_label[ptr];
            strm.out_idx   = ptr;
        end
        vote_valid = vote_valid_q;
        vote_label = best_label;
        vote_count = best_count;
        n_valid    = n_valid_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < K; i++) begin
                snap_dist[i]  <= '0;
                snap_label[i] <= '0;
            end
            ptr          <= '0;
            n_valid_q    <= '0;
            vote_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                for (int i = 0; i < K; i++) begin
                    snap_dist[i]  <= list_in[i*EW+LABEL +: DATA_W];
                    snap_label[i] <= list_in[i*EW +: LABEL];
                end
                ptr          <= '0;
                n_valid_q    <= n_valid_in;
                vote_valid_q <= 1'b0;
            end
            if (beat_fire && !beat_last) begin
                ptr <= ptr + IDX_W'(1);
            end
            // Raised on the final scan step so it is visible during DONE,
            // together with the fully resolved best candidate.
            if ((state == ST_VOTE) && scan_done) begin
                vote_valid_q <= 1'b1;
            end
        end
    end

    knn_list_reader_vote_counter #(
        .K           (K),
        .NUM_CLASSES (NUM_CLASSES),
        .LABEL       (LABEL),
        .CNT_W       (CNT_W)
    ) u_vote (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept),
        .inc        (beat_fire),
        .inc_label  (snap_label[ptr]),
        .scan_en    (state == ST_VOTE),
        .scan_done  (scan_done),
        .best_label (best_label),
        .best_count (best_count)
    );

endmodule

// File: tb/tb_knn_list_reader.sv
// tb_knn_list_reader
// Self-checking bench for knn_list_reader with K=4, NUM_CLASSES=4.
// A high-level reference model (first-empty search, label histogram,
// plurality with lowest-label tie break) produces every expected value.
module tb_knn_list_reader;

    localparam int DATA_W = 32;
    localparam int LABEL  = 8;
    localparam int K      = 4;
    localparam int NC     = 4;
    localparam int IDX_W  = 2;
    localparam int CNT_W  = 3;
    localparam int EW     = DATA_W + LABEL;
    localparam logic [DATA_W-1:0] EMPTY = '1;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [LABEL-1:0]  l;
        int                idx;
        bit                last;
    } beat_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [K*EW-1:0]     list_in;
    logic                busy;
    logic                vote_valid;
    logic [LABEL-1:0]    vote_label;
    logic [CNT_W-1:0]    vote_count;
    logic [CNT_W-1:0]    n_valid;

    knn_list_reader_if #(.DATA_W(DATA_W), .LABEL(LABEL), .IDX_W(IDX_W)) strm ();

    knn_list_reader #(
        .DATA_W      (DATA_W),
        .LABEL       (LABEL),
        .K           (K),
        .NUM_CLASSES (NC)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .list_in    (list_in),
        .busy       (busy),
        .strm       (strm),
        .vote_valid (vote_valid),
        .vote_label (vote_label),
        .vote_count (vote_count),
        .n_valid    (n_valid)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] l_dist  [K];
    logic [LABEL-1:0]  l_label [K];

    int beat_cycles [$];
    int valid_cycles;
    int done_cycle;
    int last_hs;

    task automatic set_list(input logic [DATA_W-1:0] d0, input logic [LABEL-1:0] b0,
                            input logic [DATA_W-1:0] d1, input logic [LABEL-1:0] b1,
                            input logic [DATA_W-1:0] d2, input logic [LABEL-1:0] b2,
                            input logic [DATA_W-1:0] d3, input logic [LABEL-1:0] b3);
        l_dist[0] = d0; l_label[0] = b0;
        l_dist[1] = d1; l_label[1] = b1;
        l_dist[2] = d2; l_label[2] = b2;
        l_dist[3] = d3; l_label[3] = b3;
    endtask

    // Spec-level model: valid prefix ends at the first empty distance;
    // plurality = largest histogram bin, lowest label among equals, 0 if none.
    function automatic void ref_model(output int nv, output int vlabel, output int vcount);
        int cnt [NC];
        int maxc;
        nv = K;
        for (int i = 0; i < K; i++) begin
            if (l_dist[i] == EMPTY) begin
                nv = i;
                break;
            end
        end
        for (int c = 0; c < NC; c++) cnt[c] = 0;
        for (int i = 0; i < nv; i++) begin
            if (int'(l_label[i]) < NC) cnt[l_label[i]]++;
        end
        maxc = 0;
        foreach (cnt[c]) maxc = (cnt[c] > maxc) ? cnt[c] : maxc;
        vlabel = 0;
        vcount = maxc;
        if (maxc > 0) begin
            for (int c = NC - 1; c >= 0; c--) begin
                if (cnt[c] == maxc) vlabel = c;
            end
        end
    endfunction

    // ready_mode: 0 always ready, 1 not ready in cycles 1..4, 2 random.
    // snap_hook: scramble list_in and pulse start during cycle 2.
    task automatic run_list(input string name, input int ready_mode, input bit snap_hook);
        beat_t exp_q [$];
        beat_t b;
        int    nv, vl, vc;
        logic  rdy;
        ref_model(nv, vl, vc);
        for (int i = 0; i < nv; i++) begin
            b.d = l_dist[i]; b.l = l_label[i]; b.idx = i; b.last = (i == nv - 1);
            exp_q.push_back(b);
        end
        beat_cycles.delete();
        valid_cycles = 0;
        done_cycle   = -1;
        last_hs      = -1;

        @(negedge clk);
        for (int i = 0; i < K; i++) list_in[i*EW +: EW] = {l_dist[i], l_label[i]};
        start = 1'b1;
        strm.out_ready = (ready_mode != 1);

        for (int c = 1; c <= 200 && done_cycle < 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (snap_hook && c == 2) begin
                for (int i = 0; i < K; i++) list_in[i*EW +: EW] = {$urandom(), 8'($urandom())};
                start = 1'b1;
            end
            case (ready_mode)
                1:       rdy = !(c >= 1 && c <= 4);
                2:       rdy = ($urandom_range(0, 3) != 0);
                default: rdy = 1'b1;
            endcase
            strm.out_ready = rdy;

            if (strm.out_valid === 1'b1) begin
                valid_cycles++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s extra_beat cycle %0d: got idx %0d dist %0d, none expected",
                             name, c, strm.out_idx, strm.out_dist);
                end else begin
                    b = exp_q[0];
                    if ({strm.out_dist, strm.out_label, strm.out_idx, strm.out_last} !==
                        {b.d, b.l, IDX_W'(b.idx), b.last}) begin
                        miscompares++;
                        $display("FAIL %s beat cycle %0d: got dist %0d label %0d idx %0d last %0b, want dist %0d label %0d idx %0d last %0b",
                                 name, c, strm.out_dist, strm.out_label, strm.out_idx, strm.out_last,
                                 b.d, b.l, b.idx, b.last);
                    end
                    if (rdy) begin
                        void'(exp_q.pop_front());
                        beat_cycles.push_back(c);
                        last_hs = c;
                    end
                end
            end

            if (vote_valid === 1'b1) begin
                done_cycle = c;
            end else begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s busy cycle %0d: got %0b, want 1", name, c, busy);
                end
            end
        end

        vectors++;
        if (done_cycle < 0) begin
            miscompares++;
            $display("FAIL %s vote_timeout: vote_valid never rose within 200 cycles", name);
        end else begin
            if ({vote_label, vote_count, n_valid, busy} !==
                {LABEL'(vl), CNT_W'(vc), CNT_W'(nv), 1'b0}) begin
                miscompares++;
                $display("FAIL %s vote: got label %0d count %0d n_valid %0d busy %0b, want label %0d count %0d n_valid %0d busy 0",
                         name, vote_label, vote_count, n_valid, busy, vl, vc, nv);
            end
            vectors++;
            if (exp_q.size() != 0) begin
                miscompares++;
                $display("FAIL %s beats_missing: got %0d left, want 0", name, exp_q.size());
            end
            vectors++;
            if (nv > 0) begin
                if (done_cycle != last_hs + NC + 1) begin
                    miscompares++;
                    $display("FAIL %s vote_latency: got cycle %0d, want %0d", name, done_cycle, last_hs + NC + 1);
                end
            end else if (done_cycle > 1 + NC + 1) begin
                miscompares++;
                $display("FAIL %s vote_latency_empty: got cycle %0d, want <= %0d", name, done_cycle, 1 + NC + 1);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; list_in = '0; strm.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, strm.out_valid, strm.out_dist, strm.out_label, strm.out_idx, strm.out_last,
             vote_valid, vote_label, vote_count, n_valid} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy %0b valid %0b vote_valid %0b n_valid %0d, want all 0",
                     busy, strm.out_valid, vote_valid, n_valid);
        end
        rst = 1'b1;
    endtask

    task automatic check_cycles(input string name, input int c0, input int c1, input int c2,
                                input int done_exp, input int valid_exp);
        vectors++;
        if (beat_cycles.size() != 3 || beat_cycles[0] != c0 || beat_cycles[1] != c1 ||
            beat_cycles[2] != c2 || done_cycle != done_exp || valid_cycles != valid_exp) begin
            miscompares++;
            $display("FAIL %s timing: got %0d beats, done %0d, valid cycles %0d, want beats at %0d,%0d,%0d done %0d valid cycles %0d",
                     name, beat_cycles.size(), done_cycle, valid_cycles, c0, c1, c2, done_exp, valid_exp);
        end
    endtask

    task automatic test_nominal();
        set_list(3, 1, 5, 2, 7, 1, EMPTY, 0);
        run_list("nominal", 0, 1'b0);
        check_cycles("nominal", 1, 2, 3, 8, 3);
        repeat (3) @(negedge clk);
        vectors++;
        if ({vote_valid, vote_label, vote_count} !== {1'b1, 8'd1, 3'd2}) begin
            miscompares++;
            $display("FAIL vote_hold: got valid %0b label %0d count %0d, want 1 1 2",
                     vote_valid, vote_label, vote_count);
        end
    endtask

    task automatic test_backpressure();
        set_list(3, 1, 5, 2, 7, 1, EMPTY, 0);
        run_list("backpressure", 1, 1'b0);
        check_cycles("backpressure", 5, 6, 7, 12, 7);
    endtask

    task automatic test_tie_range();
        set_list(1, 3, 2, 2, 4, 9, 6, 2);
        run_list("tie_range", 0, 1'b0);
        vectors++;
        if ({vote_label, vote_count, n_valid} !== {8'd2, 3'd2, 3'd4}) begin
            miscompares++;
            $display("FAIL tie_range_const: got label %0d count %0d n_valid %0d, want 2 2 4",
                     vote_label, vote_count, n_valid);
        end
        set_list(1, 3, 2, 2, EMPTY, 0, EMPTY, 0);
        run_list("tie_low", 0, 1'b0);
        vectors++;
        if ({vote_label, vote_count} !== {8'd2, 3'd1}) begin
            miscompares++;
            $display("FAIL tie_low_const: got label %0d count %0d, want 2 1", vote_label, vote_count);
        end
    endtask

    task automatic test_all_empty();
        set_list(EMPTY, 5, EMPTY, 1, EMPTY, 2, EMPTY, 3);
        run_list("all_empty", 0, 1'b0);
        vectors++;
        if (valid_cycles != 0) begin
            miscompares++;
            $display("FAIL all_empty_valid: got %0d valid cycles, want 0", valid_cycles);
        end
    endtask

    task automatic test_snapshot();
        set_list(3, 1, 5, 2, 7, 1, EMPTY, 0);
        run_list("snapshot", 0, 1'b1);
        check_cycles("snapshot", 1, 2, 3, 8, 3);
    endtask

    task automatic test_reset_mid();
        set_list(3, 1, 5, 2, 7, 1, EMPTY, 0);
        strm.out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < K; i++) list_in[i*EW +: EW] = {l_dist[i], l_label[i]};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, strm.out_valid, strm.out_dist, strm.out_label, strm.out_idx, strm.out_last,
             vote_valid, vote_label, vote_count, n_valid} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got busy %0b valid %0b idx %0d vote_valid %0b n_valid %0d, want all 0",
                     busy, strm.out_valid, strm.out_idx, vote_valid, n_valid);
        end
        rst = 1'b1;
        run_list("after_reset", 0, 1'b0);
        check_cycles("after_reset", 1, 2, 3, 8, 3);
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            int nv_r;
            logic [DATA_W-1:0] d;
            nv_r = $urandom_range(0, K);
            d = DATA_W'($urandom_range(0, 100));
            for (int i = 0; i < K; i++) begin
                if (i < nv_r) begin
                    l_dist[i] = d;
                    d = d + DATA_W'($urandom_range(0, 5));
                end else begin
                    l_dist[i] = EMPTY;
                end
                l_label[i] = LABEL'($urandom_range(0, 5));
            end
            run_list("random", 2, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_tie_range();
        test_all_empty();
        test_snapshot();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
